// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, the 2-way cache array and the SRAM controller.
// master: the cache controller; slave: the pipeline/cache/SRAM environment.
interface cache_controller_if #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned ADDR_IN_W = 32;

   // MEM stage side
   logic                  mem_r_en;
   logic                  mem_w_en;
   logic [ADDR_IN_W-1:0]  address;
   logic [DATA_W-1:0]     write_data;
   logic [DATA_W-1:0]     read_data;
   logic                  ready;

   // Cache array side
   logic [ADDR_W-1:0]     cache_address;
   logic [DATA_W-1:0]     cache_write_data;
   logic                  cache_wr_en;
   logic                  cache_rd_en;
   logic                  cache_inv_en;
   logic [DATA_W-1:0]     cache_read_data;
   logic                  cache_hit;

   // SRAM controller side
   logic [ADDR_W-1:0]     sram_address;
   logic [DATA_W-1:0]     sram_write_data;
   logic                  sram_r_en;
   logic                  sram_w_en;
   logic [DATA_W-1:0]     sram_read_data;
   logic                  sram_ready;

   modport master (
      input  mem_r_en, mem_w_en, address, write_data,
      output read_data, ready,
      output cache_address, cache_write_data, cache_wr_en, cache_rd_en, cache_inv_en,
      input  cache_read_data, cache_hit,
      output sram_address, sram_write_data, sram_r_en, sram_w_en,
      input  sram_read_data, sram_ready
   );

   modport slave (
      output mem_r_en, mem_w_en, address, write_data,
      input  read_data, ready,
      input  cache_address, cache_write_data, cache_wr_en, cache_rd_en, cache_inv_en,
      output cache_read_data, cache_hit,
      input  sram_address, sram_write_data, sram_r_en, sram_w_en,
      output sram_read_data, sram_ready
   );
endinterface

// File: rtl/cache_controller.sv
// Data cache controller: read-allocate, write-through, no-write-allocate.
// Zero-cycle read hits; misses and stores freeze the pipeline until sram_ready.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters.
module cache_controller #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   cache_controller_if.master  bus
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]         hit_count,
   output logic [31:0]         miss_count
`endif
);

   localparam int unsigned ADDR_IN_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } state_e;

   state_e state_q;
   state_e state_d;

   // Upper ALU address bits are outside the cached address space.
   logic addr_unused_c;
   assign addr_unused_c = ^bus.address[ADDR_IN_W-1:ADDR_W];

   // Address and data passthroughs.
   assign bus.cache_address    = bus.address[ADDR_W-1:0];
   assign bus.sram_address     = bus.address[ADDR_W-1:0];
   assign bus.sram_write_data  = bus.write_data;
   assign bus.cache_write_data = bus.sram_read_data;

   // State register; reset abandons any outstanding transaction.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and combinational strobes/handshake.
   always_comb begin
      state_d          = state_q;
      bus.ready        = 1'b0;
      bus.read_data    = bus.cache_read_data;
      bus.cache_rd_en  = 1'b0;
      bus.cache_wr_en  = 1'b0;
      bus.cache_inv_en = 1'b0;
      bus.sram_r_en    = 1'b0;
      bus.sram_w_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.mem_w_en) begin
               // Store wins over a simultaneous load; drop any stale cached copy.
               bus.cache_inv_en = 1'b1;
               bus.sram_w_en    = 1'b1;
               state_d          = WR_THRU;
            end else if (bus.mem_r_en) begin
               bus.cache_rd_en = 1'b1;
               if (bus.cache_hit) begin
                  bus.ready = 1'b1;
               end else begin
                  bus.sram_r_en = 1'b1;
                  state_d       = RD_MISS;
               end
            end else begin
               bus.ready = 1'b1;
            end
         end

         RD_MISS: begin
            bus.sram_r_en = 1'b1;
            if (bus.sram_ready) begin
               // Fill the LRU way and forward the SRAM word in the same cycle.
               bus.cache_wr_en = 1'b1;
               bus.read_data   = bus.sram_read_data;
               bus.ready       = 1'b1;
               state_d         = IDLE;
            end
         end

         WR_THRU: begin
            bus.sram_w_en = 1'b1;
            if (bus.sram_ready) begin
               bus.ready = 1'b1;
               state_d   = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (!rst) begin
         state_d          = IDLE;
         bus.ready        = 1'b0;
         bus.read_data    = '0;
         bus.cache_rd_en  = 1'b0;
         bus.cache_wr_en  = 1'b0;
         bus.cache_inv_en = 1'b0;
         bus.sram_r_en    = 1'b0;
         bus.sram_w_en    = 1'b0;
      end
   end

`ifdef CACHE_STATS_EN
   localparam int unsigned CNT_W = 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] hit_count_q;
   logic [CNT_W-1:0] hit_count_d;
   logic [CNT_W-1:0] miss_count_q;
   logic [CNT_W-1:0] miss_count_d;
   logic             hit_evt_c;
   logic             miss_evt_c;

   // Saturating event counters; stores count as neither.
   always_comb begin
      hit_evt_c    = rst && (state_q == IDLE) && !bus.mem_w_en && bus.mem_r_en && bus.cache_hit;
      miss_evt_c   = (state_q == IDLE) && (state_d == RD_MISS);
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (hit_evt_c && (hit_count_q != CNT_MAX)) begin
         hit_count_d = hit_count_q + CNT_W'(1);
      end
      if (miss_evt_c && (miss_count_q != CNT_MAX)) begin
         miss_count_d = miss_count_q + CNT_W'(1);
      end
   end

   // Counter registers, cleared on reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a completion scoreboard.
// Build with +define+CACHE_STATS_EN to also exercise the hit/miss counters.
module tb_cache_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   cache_controller_if bus ();

`ifdef CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   cache_controller dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef CACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   typedef struct {
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for ready with a cycle budget, checking the freeze cycles, then score the completion.
   task automatic complete(input logic is_read, input logic [31:0] addr, input int sram_at);
      exp_t e;
      int   lat;
      bit   done;
      done = 1'b0;
      lat  = 0;
      for (int c = 0; c < 16; c++) begin
         bus.sram_ready = (c == sram_at);
         #1;
         if (c == 0) begin
            chk("cache_address", 64'(bus.cache_address), 64'(addr[17:0]));
            chk("sram_address", 64'(bus.sram_address), 64'(addr[17:0]));
         end
         if (bus.ready === 1'b1) begin
            lat  = c;
            done = 1'b1;
            break;
         end
         chk($sformatf("c%0d_sram_r_en", c), 64'(bus.sram_r_en), 64'(is_read));
         chk($sformatf("c%0d_sram_w_en", c), 64'(bus.sram_w_en), 64'(!is_read));
         chk($sformatf("c%0d_cache_wr_en", c), 64'(bus.cache_wr_en), 64'(0));
         chk($sformatf("c%0d_cache_inv_en", c), 64'(bus.cache_inv_en), 64'((c == 0) && !is_read));
         chk($sformatf("c%0d_cache_rd_en", c), 64'(bus.cache_rd_en), 64'((c == 0) && is_read));
         tick();
      end
      if (!done) begin
         chk("timeout_ready", 64'(bus.ready), 64'(1));
      end else if (sb.size() == 0) begin
         chk("scoreboard_empty", 64'(sb.size()), 64'(1));
      end else begin
         e = sb.pop_front();
         chk("latency", 64'(lat), 64'(e.lat));
         if (is_read) begin
            chk("read_data", 64'(bus.read_data), 64'(e.data));
            chk("fill_wr_en", 64'(bus.cache_wr_en), 64'(e.lat != 0));
            if (e.lat != 0) begin
               chk("fill_data", 64'(bus.cache_write_data), 64'(e.data));
            end else begin
               chk("hit_rd_en", 64'(bus.cache_rd_en), 64'(1));
               chk("hit_sram_r_en", 64'(bus.sram_r_en), 64'(0));
            end
         end else begin
            chk("wr_cache_wr_en", 64'(bus.cache_wr_en), 64'(0));
            chk("wr_sram_w_en", 64'(bus.sram_w_en), 64'(1));
            chk("wr_sram_data", 64'(bus.sram_write_data), 64'(e.data));
         end
      end
      tick();
      bus.sram_ready = 1'b0;
   endtask

   task automatic req_read(input logic [31:0] addr, input logic hit, input logic [31:0] cdata,
                           input logic [31:0] sdata, input int sram_at);
      exp_t e;
      bus.mem_r_en        = 1'b1;
      bus.mem_w_en        = 1'b0;
      bus.address         = addr;
      bus.cache_hit       = hit;
      bus.cache_read_data = cdata;
      bus.sram_read_data  = sdata;
      e.data = hit ? cdata : sdata;
      e.lat  = hit ? 0 : sram_at;
      sb.push_back(e);
      complete(1'b1, addr, sram_at);
   endtask

   task automatic req_write(input logic [31:0] addr, input logic [31:0] wdata, input logic also_read,
                            input int sram_at);
      exp_t e;
      bus.mem_r_en        = also_read;
      bus.mem_w_en        = 1'b1;
      bus.address         = addr;
      bus.write_data      = wdata;
      bus.cache_hit       = 1'b1;
      bus.cache_read_data = 32'h0BAD0BAD;
      e.data = wdata;
      e.lat  = sram_at;
      sb.push_back(e);
      complete(1'b0, addr, sram_at);
   endtask

   task automatic idle_cycle(input logic sram_rdy);
      bus.mem_r_en        = 1'b0;
      bus.mem_w_en        = 1'b0;
      bus.cache_hit       = 1'b0;
      bus.sram_ready      = sram_rdy;
      bus.cache_read_data = 32'h55AA33CC;
      #1;
      chk("idle_ready", 64'(bus.ready), 64'(1));
      chk("idle_read_data", 64'(bus.read_data), 64'(32'h55AA33CC));
      chk("idle_cache_wr_en", 64'(bus.cache_wr_en), 64'(0));
      chk("idle_sram_r_en", 64'(bus.sram_r_en), 64'(0));
      chk("idle_sram_w_en", 64'(bus.sram_w_en), 64'(0));
      tick();
      bus.sram_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held two cycles with a pending load.
      bus.mem_r_en        = 1'b1;
      bus.mem_w_en        = 1'b0;
      bus.address         = 32'h0000_0400;
      bus.write_data      = 32'h0;
      bus.cache_hit       = 1'b0;
      bus.cache_read_data = 32'h1111_2222;
      bus.sram_read_data  = 32'h3333_4444;
      bus.sram_ready      = 1'b0;
      rst = 1'b0;
      #2;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst%0d_ready", i), 64'(bus.ready), 64'(0));
         chk($sformatf("rst%0d_sram_r_en", i), 64'(bus.sram_r_en), 64'(0));
         chk($sformatf("rst%0d_cache_wr_en", i), 64'(bus.cache_wr_en), 64'(0));
         chk($sformatf("rst%0d_read_data", i), 64'(bus.read_data), 64'(0));
         tick();
      end
      rst = 1'b1;
      idle_cycle(1'b0);

      // Read hit, zero latency.
      req_read(32'h0000_0404, 1'b1, 32'hDEADBEEF, 32'h0, 99);
      idle_cycle(1'b0);

      // Read miss, sram_ready four cycles after the request.
      req_read(32'h0000_0408, 1'b0, 32'h0BAD0BAD, 32'h12345678, 4);

      // Write-through, back-to-back with the miss completion.
      req_write(32'h0000_040C, 32'hCAFEF00D, 1'b0, 3);

      // Back-to-back hit right after the store completes.
      req_read(32'h0000_0410, 1'b1, 32'hA5A5_0001, 32'h0, 99);

      // Minimum latency miss and store.
      req_read(32'h0003_FFFC, 1'b0, 32'h0BAD0BAD, 32'h7777_8888, 1);
      req_write(32'hFFFF_0014, 32'h0102_0304, 1'b0, 1);

      // Load and store together: store wins, load ignored.
      req_write(32'h0000_0418, 32'h9999_AAAA, 1'b1, 2);

      // Stray sram_ready in IDLE is ignored.
      idle_cycle(1'b1);
      idle_cycle(1'b0);

      // Reset in the middle of a miss abandons it with no fill.
      bus.mem_r_en  = 1'b1;
      bus.cache_hit = 1'b0;
      bus.address   = 32'h0000_0420;
      #1;
      chk("rm_req_sram_r_en", 64'(bus.sram_r_en), 64'(1));
      tick();
      rst = 1'b0;
      #1;
      chk("rm_rst_ready", 64'(bus.ready), 64'(0));
      chk("rm_rst_sram_r_en", 64'(bus.sram_r_en), 64'(0));
      tick();
      bus.sram_ready     = 1'b1;
      bus.sram_read_data = 32'hFEED_FACE;
      #1;
      chk("rm_rst_fill", 64'(bus.cache_wr_en), 64'(0));
      tick();
      rst          = 1'b1;
      bus.mem_r_en = 1'b0;
      #1;
      chk("rm_post_fill", 64'(bus.cache_wr_en), 64'(0));
      chk("rm_post_sram_r_en", 64'(bus.sram_r_en), 64'(0));
      chk("rm_post_ready", 64'(bus.ready), 64'(1));
      tick();
      bus.sram_ready = 1'b0;
      idle_cycle(1'b0);
      req_read(32'h0000_0424, 1'b1, 32'h4242_4242, 32'h0, 99);

`ifdef CACHE_STATS_EN
      // Counter section from a clean reset: 3 hits, 2 misses, 1 store, 1 load+store.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("stats_rst_hits", 64'(hit_count), 64'(0));
      chk("stats_rst_misses", 64'(miss_count), 64'(0));
      for (int i = 0; i < 3; i++) begin
         req_read(32'h0000_0500 + 32'(i * 4), 1'b1, 32'h1000 + 32'(i), 32'h0, 99);
      end
      req_read(32'h0000_0600, 1'b0, 32'h0BAD0BAD, 32'h2000, 1);
      req_read(32'h0000_0604, 1'b0, 32'h0BAD0BAD, 32'h2001, 3);
      req_write(32'h0000_0608, 32'h3000, 1'b0, 2);
      req_write(32'h0000_060C, 32'h3001, 1'b1, 1);
      idle_cycle(1'b0);
      chk("stats_hits", 64'(hit_count), 64'(3));
      chk("stats_misses", 64'(miss_count), 64'(2));
`endif

      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Initiator side of the 2-way data cache interface. Sits between the MEM stage and both the cache array and the SRAM controller.
- Issues cache lookups, fills and invalidations. Services misses and write-through from SRAM.
- Drives `ready` to freeze the pipeline while an SRAM transaction is outstanding.
- Policy: read-allocate, write-through, no-write-allocate.

Parameters:
- ADDR_W, 18, word-aligned byte address width presented to cache and SRAM
- DATA_W, 32, data word width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-low
- mem_r_en  input  1  MEM-stage load request
- mem_w_en  input  1  MEM-stage store request
- address  input  32  byte address from ALU; bits [17:0] used, [1:0] ignored
- write_data  input  32  store data
- read_data  output  32  load result
- ready  output  1  1 = request complete or no request; 0 = freeze pipeline
- cache_address  output  18  address[17:0] passthrough
- cache_write_data  output  32  fill data
- cache_wr_en  output  1  fill strobe: cache writes LRU way, toggles LRU
- cache_rd_en  output  1  lookup strobe: cache updates LRU on hit
- cache_inv_en  output  1  clear valid bit of the matching way
- cache_read_data  input  32  cache data out
- cache_hit  input  1  combinational hit from cache
- sram_address  output  18  address[17:0] passthrough
- sram_write_data  output  32  write_data passthrough
- sram_r_en  output  1  SRAM read request, level, held until sram_ready
- sram_w_en  output  1  SRAM write request, level, held until sram_ready
- sram_read_data  input  32  SRAM read data, valid with sram_ready
- sram_ready  input  1  one-cycle completion pulse from SRAM controller

Behaviour:
- Reset:
  - Synchronous, active-low. Edge with rst=0 forces state to IDLE.
  - While rst=0, all strobes (cache_*_en, sram_*_en) are 0, ready=0, read_data=0.
  - Asserting rst mid-transaction abandons the transaction. No fill is written.
- FSM states: IDLE, RD_MISS, WR_THRU. State is registered; outputs are combinational from state and inputs.
- Request inputs must be held stable by the pipeline until ready=1 (pipeline frozen).
- IDLE, no request: ready=1, all strobes 0, read_data=cache_read_data.
- IDLE, mem_r_en=1, cache_hit=1:
  - cache_rd_en=1, read_data=cache_read_data, ready=1 in the same cycle (0-cycle hit latency).
  - State stays IDLE.
- IDLE, mem_r_en=1, cache_hit=0:
  - ready=0, cache_rd_en=1, sram_r_en=1. Next state RD_MISS.
- RD_MISS:
  - sram_r_en=1, ready=0 until sram_ready=1.
  - On the sram_ready cycle: cache_wr_en=1, cache_write_data=sram_read_data, read_data=sram_read_data, ready=1. Next state IDLE.
- IDLE, mem_w_en=1:
  - ready=0, cache_inv_en=1 (one cycle only), sram_w_en=1. Next state WR_THRU.
- WR_THRU:
  - sram_w_en=1, ready=0.
  - On sram_ready=1: ready=1, next state IDLE. Cache is not written.
- Simultaneous mem_r_en=1 and mem_w_en=1: write takes priority and read is ignored; treated as a protocol error.
- sram_ready in IDLE is ignored.
- A back-to-back request in the cycle after completion is accepted in IDLE normally (no bubble state).
- Minimum miss and write latency: 2 cycles (request cycle plus sram_ready cycle).

Optional Feature:
- Macro: CACHE_STATS_EN
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0]. Both cleared on reset.
  - hit_count increments once per read hit in IDLE.
  - miss_count increments once per IDLE→RD_MISS transition.
  - Both counters saturate at 32'hFFFFFFFF. Writes count as neither.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_r_en=1 -> ready=0, sram_r_en=0, cache_wr_en=0; after release, state is IDLE.
- Read hit: mem_r_en=1, address=0x00000404, cache_hit=1, cache_read_data=0xDEADBEEF -> same cycle ready=1, read_data=0xDEADBEEF, cache_rd_en=1, sram_r_en=0.
- Read miss:
  - Stimulus: address=0x00000408, cache_hit=0; sram_ready pulses 4 cycles later with sram_read_data=0x12345678.
  - Response: ready=0 for 4 cycles, sram_address=0x00408. In the sram_ready cycle: cache_wr_en=1, cache_write_data=0x12345678, read_data=0x12345678, ready=1.
- Write-through: mem_w_en=1, address=0x0000040C, write_data=0xCAFEF00D, sram_ready after 3 cycles -> cache_inv_en high only in the first cycle, sram_w_en high until sram_ready, ready=1 on that cycle, cache_wr_en never 1.
- Reset mid-miss: rst=0 during RD_MISS, then sram_ready arrives -> no cache_wr_en, state IDLE, ready=1 once rst=1 with no request.
- With CACHE_STATS_EN: 3 hits, then 2 misses, then 1 write -> hit_count=3, miss_count=2.
